// File: rtl/harris_window_ctrl.sv
// Sequencer for the Harris corner datapath: raster counters from VGA timing, line-buffer
// control, full-window tagging aligned to datapath latency, and per-frame best-corner tracking.
module harris_window_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int WIN      = 5,
    parameter int PIPE_LAT = 3,
    parameter int SCORE_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               VGA_BLANK,
    input  logic               VGA_VS,
    input  logic               corner_detected,
    input  logic [SCORE_W-1:0] corner_score,
    output logic               buf_shift_en,
    output logic               buf_aclr,
    output logic               win_valid,
    output logic               best_valid,
    output logic [9:0]         best_x,
    output logic [9:0]         best_y,
    output logic [SCORE_W-1:0] best_score,
    output logic               frame_done,
    output logic               line_err
);

    localparam logic [9:0] X_LIM   = 10'(H_ACTIVE);
    localparam logic [9:0] Y_LIM   = 10'(V_ACTIVE);
    localparam logic [9:0] EDGE    = 10'(WIN - 1);
    localparam logic [9:0] CTR     = 10'(WIN / 2);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic {WAIT_VS, FRAME} state_t;

    state_t               state_reg;
    logic                 vs_reg;
    logic [9:0]           pix_x_reg, pix_y_reg;
    logic                 cand_any_reg;
    logic [9:0]           cand_x_reg, cand_y_reg;
    logic [SCORE_W-1:0]   cand_score_reg;

    logic                 dl_valid_reg [PIPE_LAT];
    logic [9:0]           dl_x_reg     [PIPE_LAT];
    logic [9:0]           dl_y_reg     [PIPE_LAT];
    logic                 dl_valid_next[PIPE_LAT];
    logic [9:0]           dl_x_next    [PIPE_LAT];
    logic [9:0]           dl_y_next    [PIPE_LAT];

    logic in_frame, vs_fall, tag_valid, take_corner;

    assign in_frame     = (state_reg == FRAME);
    assign vs_fall      = vs_reg & ~VGA_VS;
    assign buf_shift_en = in_frame & VGA_BLANK & (pix_x_reg < X_LIM) & (pix_y_reg < Y_LIM);
    assign tag_valid    = (pix_x_reg >= EDGE) & (pix_y_reg >= EDGE);
    assign win_valid    = dl_valid_reg[PIPE_LAT-1];
    assign take_corner  = win_valid & corner_detected &
                          (~cand_any_reg | (corner_score > cand_score_reg));

    // Non-shift cycles push an invalid tag so the tail stays aligned to the datapath.
    generate
        for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                assign dl_valid_next[gi] = buf_shift_en & tag_valid;
                assign dl_x_next[gi]     = pix_x_reg - CTR;
                assign dl_y_next[gi]     = pix_y_reg - CTR;
            end else begin : g_tail
                assign dl_valid_next[gi] = dl_valid_reg[gi-1];
                assign dl_x_next[gi]     = dl_x_reg[gi-1];
                assign dl_y_next[gi]     = dl_y_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < PIPE_LAT; i++) begin
            if (!reset || vs_fall) begin
                dl_valid_reg[i] <= 1'b0;
                dl_x_reg[i]     <= '0;
                dl_y_reg[i]     <= '0;
            end else begin
                dl_valid_reg[i] <= dl_valid_next[i];
                dl_x_reg[i]     <= dl_x_next[i];
                dl_y_reg[i]     <= dl_y_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= WAIT_VS;
            vs_reg         <= 1'b0;
            pix_x_reg      <= '0;
            pix_y_reg      <= '0;
            cand_any_reg   <= 1'b0;
            cand_x_reg     <= '0;
            cand_y_reg     <= '0;
            cand_score_reg <= '0;
            best_valid     <= 1'b0;
            best_x         <= '0;
            best_y         <= '0;
            best_score     <= '0;
            frame_done     <= 1'b0;
            line_err       <= 1'b0;
            buf_aclr       <= 1'b1;
        end else begin
            vs_reg     <= VGA_VS;
            frame_done <= 1'b0;
            buf_aclr   <= ~VGA_VS | (state_reg == WAIT_VS);
            if (in_frame && VGA_BLANK && pix_x_reg >= X_LIM)
                line_err <= 1'b1;

            if (vs_fall) begin
                // The first sync edge only opens a frame; later ones also close the previous one.
                state_reg <= FRAME;
                pix_x_reg <= '0;
                pix_y_reg <= '0;
                if (in_frame) begin
                    frame_done <= 1'b1;
                    best_valid <= cand_any_reg;
                    if (cand_any_reg) begin
                        best_x     <= cand_x_reg;
                        best_y     <= cand_y_reg;
                        best_score <= cand_score_reg;
                    end
                end
                cand_any_reg   <= 1'b0;
                cand_x_reg     <= '0;
                cand_y_reg     <= '0;
                cand_score_reg <= '0;
            end else begin
                if (in_frame) begin
                    if (VGA_BLANK) begin
                        if (pix_x_reg != CNT_MAX)
                            pix_x_reg <= pix_x_reg + 10'd1;
                    end else if (pix_x_reg != 10'd0) begin
                        pix_x_reg <= '0;
                        if (pix_y_reg != CNT_MAX)
                            pix_y_reg <= pix_y_reg + 10'd1;
                    end
                end
                // Strict compare so equal scores keep the earlier corner in raster order.
                if (take_corner) begin
                    cand_any_reg   <= 1'b1;
                    cand_x_reg     <= dl_x_reg[PIPE_LAT-1];
                    cand_y_reg     <= dl_y_reg[PIPE_LAT-1];
                    cand_score_reg <= corner_score;
                end
            end
        end
    end

endmodule

// File: tb/tb_harris_window_ctrl.sv
// Bench for harris_window_ctrl on a reduced 64x40 raster: frame table with corner lists,
// scoreboard of expected per-frame best corners popped on frame_done, plus corner sequences.
module tb_harris_window_ctrl;

    localparam int H  = 64;
    localparam int V  = 40;
    localparam int HB = 8;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        VGA_BLANK, VGA_VS, corner_detected;
    logic [15:0] corner_score;
    logic        buf_shift_en, buf_aclr, win_valid, best_valid, frame_done, line_err;
    logic [9:0]  best_x, best_y;
    logic [15:0] best_score;

    harris_window_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .WIN(5), .PIPE_LAT(LAT), .SCORE_W(16)) dut (
        .clk(clk), .reset(reset), .VGA_BLANK(VGA_BLANK), .VGA_VS(VGA_VS),
        .corner_detected(corner_detected), .corner_score(corner_score),
        .buf_shift_en(buf_shift_en), .buf_aclr(buf_aclr), .win_valid(win_valid),
        .best_valid(best_valid), .best_x(best_x), .best_y(best_y), .best_score(best_score),
        .frame_done(frame_done), .line_err(line_err)
    );

    always #5 clk = ~clk;

    typedef struct { int f; int x; int y; logic [15:0] sc; } corner_t;
    typedef struct { int nlines; bit ev; int ex; int ey; int es; } vec_t;
    typedef struct { bit v; int x; int y; int s; } exp_t;
    typedef struct { int due; logic [15:0] sc; bit wv; } pend_t;

    corner_t ctab[$];
    vec_t    vtab[7];
    exp_t    sb[$];
    pend_t   pend[$];

    int errors = 0;
    int checks = 0;
    int k = 0;
    int shift_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One cycle: drive at negedge, fire any corner due now, sample 1ns later.
    task automatic tick(input logic b, input logic v);
        bit hit;
        @(negedge clk);
        VGA_BLANK = b;
        VGA_VS    = v;
        k++;
        hit = (pend.size() > 0) && (pend[0].due == k);
        if (hit) begin
            corner_detected = 1'b1;
            corner_score    = pend[0].sc;
        end else begin
            corner_detected = 1'b0;
            corner_score    = 16'($urandom);
        end
        #1;
        if (buf_shift_en) shift_cnt++;
        if (hit) begin
            chk("win_valid_at_corner", int'(win_valid), int'(pend[0].wv));
            pend.pop_front();
        end
    endtask

    task automatic vs_pulse();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1'b0, 1'b1);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got none expected pulse");
            sb.delete();
        end
    endtask

    task automatic drive_frame(input int f, input int nlines, input int long_line);
        int len;
        shift_cnt = 0;
        repeat (4) tick(1'b0, 1'b1);
        for (int y = 0; y < nlines; y++) begin
            len = (y == long_line) ? H + 10 : H;
            for (int x = 0; x < len; x++) begin
                foreach (ctab[i])
                    if (ctab[i].f == f && ctab[i].x == x && ctab[i].y == y)
                        pend.push_back('{k + 1 + LAT, ctab[i].sc, (x >= 4 && y >= 4)});
                tick(1'b1, 1'b1);
            end
            repeat (HB) tick(1'b0, 1'b1);
        end
        repeat (4) tick(1'b0, 1'b1);
        chk($sformatf("shift_count_f%0d", f), shift_cnt, H * nlines);
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_done_unexpected: got pulse expected none at cycle %0d", k);
            end else begin
                chk("best_valid", int'(best_valid), int'(sb[0].v));
                chk("best_x", int'(best_x), sb[0].x);
                chk("best_y", int'(best_y), sb[0].y);
                chk("best_score", int'(best_score), sb[0].s);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        vtab[0] = '{V,  1'b0, 0,  0,  0};
        vtab[1] = '{V,  1'b1, 28, 18, 'h0200};
        vtab[2] = '{V,  1'b1, 38, 28, 'h0180};
        vtab[3] = '{25, 1'b1, 8,  8,  'h0100};
        vtab[4] = '{V,  1'b1, 10, 10, 'h0050};
        vtab[5] = '{V,  1'b0, 10, 10, 'h0050};
        vtab[6] = '{V,  1'b1, 2,  2,  'h0010};
        ctab.push_back('{1, 30, 20, 16'h0200});
        ctab.push_back('{2, 10, 10, 16'h0100});
        ctab.push_back('{2, 30, 20, 16'h0100});
        ctab.push_back('{2, 40, 30, 16'h0180});
        ctab.push_back('{3, 10, 10, 16'h0100});
        ctab.push_back('{3, 30, 20, 16'h0100});
        ctab.push_back('{4, 20, 2,  16'hFFFF});
        ctab.push_back('{4, 3,  20, 16'hFFFF});
        ctab.push_back('{4, 12, 12, 16'h0050});
        ctab.push_back('{5, 3,  20, 16'hFFFF});
        ctab.push_back('{6, 4,  4,  16'h0010});
        ctab.push_back('{6, 63, 39, 16'h0010});
        ctab.push_back('{7, 20, 10, 16'h0300});

        reset = 1'b0;
        VGA_BLANK = 1'b0;
        VGA_VS = 1'b1;
        corner_detected = 1'b0;
        corner_score = '0;
        repeat (3) tick(1'b0, 1'b1);
        chk("rst_best_valid", int'(best_valid), 0);
        chk("rst_best_x", int'(best_x), 0);
        chk("rst_best_score", int'(best_score), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_line_err", int'(line_err), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_buf_aclr", int'(buf_aclr), 1);
        reset = 1'b1;
        tick(1'b1, 1'b1);
        chk("wait_vs_no_shift", int'(buf_shift_en), 0);

        vs_pulse();
        for (int f = 0; f < 7; f++) begin
            drive_frame(f, vtab[f].nlines, -1);
            chk($sformatf("aclr_idle_f%0d", f), int'(buf_aclr), 0);
            sb.push_back('{vtab[f].ev, vtab[f].ex, vtab[f].ey, vtab[f].es});
            vs_pulse();
            wait_done();
        end
        chk("line_err_clean", int'(line_err), 0);

        // Over-long line: shifting stops at H, error is sticky across the sync edge.
        drive_frame(-1, V, 5);
        chk("line_err_set", int'(line_err), 1);
        sb.push_back('{1'b0, 2, 2, 'h0010});
        vs_pulse();
        wait_done();
        chk("line_err_sticky", int'(line_err), 1);

        // Reset mid-frame: candidate discarded, first sync only reopens.
        drive_frame(7, 20, -1);
        reset = 1'b0;
        tick(1'b1, 1'b1);
        reset = 1'b1;
        tick(1'b1, 1'b1);
        chk("mid_rst_best_valid", int'(best_valid), 0);
        chk("mid_rst_best_x", int'(best_x), 0);
        chk("mid_rst_line_err", int'(line_err), 0);
        chk("mid_rst_shift_en", int'(buf_shift_en), 0);
        chk("mid_rst_buf_aclr", int'(buf_aclr), 1);
        d0 = done_cnt;
        vs_pulse();
        repeat (5) tick(1'b0, 1'b1);
        chk("first_vs_no_done", done_cnt, d0);
        drive_frame(7, V, -1);
        sb.push_back('{1'b1, 18, 8, 'h0300});
        vs_pulse();
        wait_done();
        chk("second_vs_done", done_cnt, d0 + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
